// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES round sequencer: FSM states, mode encoding
// and the Nk -> Nr mapping.
package aes_round_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_INIT,
      ST_ROUND,
      ST_FINAL,
      ST_HOLD
   } seq_state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   localparam int NR_NK4 = 10;
   localparam int NR_NK6 = 12;
   localparam int NR_NK8 = 14;

   function automatic int nr_for_nk(input int nk);
      case (nk)
         6:       return NR_NK6;
         8:       return NR_NK8;
         default: return NR_NK4;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_sequencer_counter.sv
// Loadable 4-bit round counter with clear, enable and a flag for the last
// full round (count == Nr-1). Saturates at Nr.
module aes_round_counter #(
   parameter int Nr = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       en,
   output logic [3:0] count,
   output logic       terminal
);

   localparam logic [3:0] NR4 = 4'(Nr);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != NR4)) begin
         count <= count + 4'd1;
      end
   end

   assign terminal = (count == NR4 - 4'd1);

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative one-round-per-cycle AES engine: handshake,
// optional key expansion, rounds 0..Nr, and result hold with backpressure.
module aes_round_sequencer
   import aes_round_sequencer_pkg::*;
#(
   parameter int Nk = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mode,
   input  logic       new_key,
   input  logic       abort,
   input  logic       key_done,
   input  logic       out_ready,
   output logic       ready,
   output logic       busy,
   output logic       key_start,
   output logic       load_state,
   output logic       round_en,
   output logic       last_round,
   output logic       inv,
   output logic [3:0] round_idx,
   output logic [3:0] rk_idx,
   output logic       out_valid
);

   localparam int         Nr  = nr_for_nk(Nk);
   localparam logic [3:0] NR4 = 4'(Nr);

   seq_state_t state, state_next;
   logic       key_loaded;
   logic       inv_q;
   logic       key_first;
   logic       cnt_clear, cnt_load, cnt_en, cnt_terminal;
   logic [3:0] cnt;

   aes_round_counter #(.Nr(Nr)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .load_val (4'd1),
      .en       (cnt_en),
      .count    (cnt),
      .terminal (cnt_terminal)
   );

   // Abort overrides every normal transition; leaving for IDLE always zeroes the counter.
   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      case (state)
         ST_IDLE:   if (start) state_next = (new_key || !key_loaded) ? ST_KEYEXP : ST_INIT;
         ST_KEYEXP: if (key_done) state_next = ST_INIT;
         ST_INIT: begin
            cnt_load   = 1'b1;
            state_next = ST_ROUND;
         end
         ST_ROUND: begin
            cnt_en = 1'b1;
            if (cnt_terminal) state_next = ST_FINAL;
         end
         ST_FINAL:  state_next = ST_HOLD;
         ST_HOLD:   if (out_ready) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
      if (abort && (state != ST_IDLE)) begin
         state_next = ST_IDLE;
         cnt_load   = 1'b0;
         cnt_en     = 1'b0;
      end
      cnt_clear = (state_next == ST_IDLE);
   end

   // key_first marks the first KEYEXP cycle so key_start is a single pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         key_loaded <= 1'b0;
         inv_q      <= MODE_ENC;
         key_first  <= 1'b0;
      end else begin
         state     <= state_next;
         key_first <= (state != ST_KEYEXP) && (state_next == ST_KEYEXP);
         if ((state == ST_IDLE) && start) begin
            inv_q <= (mode == MODE_DEC);
         end
         if (abort && (state == ST_KEYEXP)) begin
            key_loaded <= 1'b0;
         end else if ((state == ST_KEYEXP) && key_done) begin
            key_loaded <= 1'b1;
         end
      end
   end

   assign ready      = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign key_start  = (state == ST_KEYEXP) && key_first;
   assign load_state = (state == ST_INIT);
   assign round_en   = (state == ST_ROUND) || (state == ST_FINAL);
   assign last_round = (state == ST_FINAL);
   assign out_valid  = (state == ST_HOLD);
   assign inv        = inv_q;
   assign round_idx  = cnt;
   assign rk_idx     = inv_q ? (NR4 - cnt) : cnt;

endmodule
